// File: rtl/inst_loader.sv
// inst_loader: assembles a little-endian byte stream into 32-bit words and writes them into instruction RAM.
// Holds the CPU in reset while a load session runs; reports progress, completion and a byte checksum.
module inst_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        checksum
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   FULL = (ADDR_W + 1)'(DEPTH);
  state_t            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       bytes_q, bytes_d;
  logic [ADDR_W-1:0] addr_q, addr_d, mem_addr_q, mem_addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [7:0]        sum_q, sum_d;
  logic              done_q, done_d, crst_q, crst_d;
  logic              accept;
  // Gating ready with load_en makes an abort win over a same-cycle byte.
  assign byte_ready = (state_q == COLLECT) && load_en;
  assign accept     = byte_valid && byte_ready;
  assign mem_we     = (state_q == WRITE);
  assign busy       = (state_q == COLLECT) || (state_q == WRITE);
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = wdata_q;
  assign cpu_rst_n  = crst_q;
  assign done       = done_q;
  assign word_count = cnt_q;
  assign checksum   = sum_q;
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    bytes_d    = bytes_q;
    addr_d     = addr_q;
    mem_addr_d = mem_addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    sum_d      = sum_q;
    done_d     = done_q;
    crst_d     = (state_q == IDLE) && !load_en;
    case (state_q)
      IDLE: if (load_en) begin
        state_d = COLLECT;
        idx_d   = '0;
        addr_d  = '0;
        cnt_d   = '0;
        sum_d   = '0;
        done_d  = 1'b0;
      end
      COLLECT: if (!load_en) begin
        state_d = IDLE;
      end else if (accept) begin
        sum_d = sum_q + byte_data;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          wdata_d    = {byte_data, bytes_q};
          mem_addr_d = addr_q;
          state_d    = WRITE;
        end else begin
          bytes_d[{idx_q, 3'b000} +: 8] = byte_data;
        end
      end
      WRITE: begin
        cnt_d = (cnt_q == FULL) ? cnt_q : cnt_q + 1'b1;
        if (addr_q == LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = load_en ? COLLECT : IDLE;
        end
      end
      default: state_d = load_en ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      bytes_q    <= '0;
      addr_q     <= '0;
      mem_addr_q <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      sum_q      <= '0;
      done_q     <= 1'b0;
      crst_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      bytes_q    <= bytes_d;
      addr_q     <= addr_d;
      mem_addr_q <= mem_addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      sum_q      <= sum_d;
      done_q     <= done_d;
      crst_q     <= crst_d;
    end
  end
endmodule
